tlb_port_arbiter: RTL and testbench
===================================

Name: tlb_port_arbiter

Overview:
- Shares the single TLB lookup port between two requesters: instruction fetch (F, read-only) and the MEM stage (M, read or write).
- Sequences each lookup through a small FSM and registers the TLB result (PF, miss, protection) for the winner.
- M has fixed priority over F, with a starvation limit that forces an F grant.
- Sits between the fetch/MEM stages and the 8-entry combinational TLB; its miss/prot outputs feed the page-fault and protection bits of IE_type.

Parameters:
- STARVE_LIM, 3, number of consecutive lost arbitrations after which a waiting F beats M (1..7).
- PF_W, 20, physical frame number width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush; cancels in-flight lookup
- f_req  in  1  fetch lookup request
- f_vaddr  in  32  fetch virtual address
- m_req  in  1  MEM lookup request
- m_vaddr  in  32  MEM virtual address
- m_rw  in  1  MEM access type, 1 = write
- f_done  out  1  one-cycle pulse: fetch result valid
- m_done  out  1  one-cycle pulse: MEM result valid
- pf_out  out  PF_W  registered physical frame
- miss_out  out  1  registered TLB miss (page fault)
- prot_out  out  1  registered protection exception
- busy  out  1  FSM not in IDLE
- tlb_addr  out  32  address driven to TLB
- tlb_rw  out  1  access type driven to TLB
- tlb_pf  in  PF_W  TLB frame output
- tlb_hit  in  1  TLB hit
- tlb_miss  in  1  TLB miss
- tlb_prot  in  1  TLB protection violation

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0, including tlb_addr, tlb_rw, pf_out and the age counter.
- States:
  - IDLE: if any req and !flush, perform arbitration, latch winner ID, vaddr and rw (F always rw=0), then go to LKUP.
  - LKUP: tlb_addr/tlb_rw come from the latched registers. At the clock edge, capture tlb_pf, tlb_miss and tlb_prot into pf_out/miss_out/prot_out, then go to RESP.
  - RESP: assert the winner's done for exactly this cycle. If another req is pending and !flush, arbitrate and go directly to LKUP (back-to-back). Otherwise go to IDLE.
- Latency: req sampled in cycle 0 gives done in cycle 2. Sustained throughput is one lookup per 2 cycles.
- Arbitration:
  - Only M requests: M wins. Only F requests: F wins.
  - Both request: M wins unless age == STARVE_LIM, in which case F wins.
  - age increments (saturating at STARVE_LIM) on each arbitration where F requested and lost.
  - age clears when F is granted, or on any arbitration where f_req=0.
- Requesters hold req/vaddr/rw until their done. Dropping req after grant does not cancel; done still pulses and the requester ignores it.
- pf_out/miss_out/prot_out hold their values until the next capture. They are valid only in the done cycle.
- If tlb_hit and tlb_miss are both 1 (illegal), miss takes precedence: miss_out=1 and pf_out is captured anyway.
- Flush:
  - In IDLE: no grant that cycle.
  - In LKUP: no capture, no done, return to IDLE; age is unchanged.
  - In RESP: done is suppressed; return to IDLE.
  - Flush outranks a simultaneous new req.
- busy = (state != IDLE).
- Reset mid-lookup: immediate return to IDLE with outputs 0; no done is ever emitted for the aborted lookup.

Decomposition:
- Shared package:
  - state encodings (IDLE=2'b00, LKUP=2'b01, RESP=2'b10)
  - requester IDs (REQ_F=0, REQ_M=1)
  - PF_W
  - exception bit positions in IE_type (bit0 prot, bit1 page fault)
- One sub-module: tlb_arb_age_ctr, the saturating 3-bit starvation counter with inc/clr/at_lim.

Test Plan:
- Only f_req=1, f_vaddr=0x0040_1000, TLB returns pf=0x12345, hit → tlb_addr=0x0040_1000 in cycle 1; f_done=1 in cycle 2, pf_out=0x12345, miss_out=0, prot_out=0.
- m_req=1, m_rw=1, TLB returns tlb_prot=1 → m_done in cycle 2 with prot_out=1, tlb_rw=1 during LKUP.
- f_req and m_req both held high continuously with STARVE_LIM=3 → grant order M,M,M,F,M,M,M,F; done pulses every 2 cycles, no idle cycles between lookups.
- m_req with TLB miss (tlb_miss=1) → m_done cycle 2, miss_out=1; f_req raised in RESP cycle → LKUP for F the next cycle.
- flush=1 during LKUP → no done, busy=0 next cycle, pf_out keeps its prior value; a held request is re-granted on the following cycle.
- rst asserted low during LKUP → all outputs 0 immediately; after release with no req, busy stays 0 and no done pulses occur.

Source files
------------

// File: rtl/tlb_port_arbiter_pkg.sv
// Shared types and constants for the TLB lookup-port arbiter.
package tlb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LKUP = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_M = 1'b1
    } req_id_e;

    localparam int unsigned PF_W_DEFAULT = 20;

    // Bit positions of the exception flags inside IE_type.
    localparam int unsigned IE_PROT_BIT = 0;
    localparam int unsigned IE_PF_BIT   = 1;

    function automatic logic [1:0] ie_bits(input logic miss, input logic prot);
        logic [1:0] v;
        v              = '0;
        v[IE_PROT_BIT] = prot;
        v[IE_PF_BIT]   = miss;
        return v;
    endfunction

endpackage

// File: rtl/tlb_arb_age_ctr.sv
// Saturating starvation counter: counts fetch arbitration losses up to LIM.
module tlb_arb_age_ctr #(
    parameter int unsigned LIM = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_lim_o
);

    localparam logic [2:0] LIM_V = 3'(LIM);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIM_V)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_lim_o = (cnt_q == LIM_V);

endmodule

// File: rtl/tlb_port_arbiter.sv
// Shares the single TLB lookup port between fetch (F) and MEM (M), one
// lookup per two cycles, M priority with a starvation override for F.
module tlb_port_arbiter
    import tlb_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 3,
    parameter int unsigned PF_W       = PF_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            f_req_i,
    input  logic [31:0]     f_vaddr_i,
    input  logic            m_req_i,
    input  logic [31:0]     m_vaddr_i,
    input  logic            m_rw_i,
    output logic            f_done_o,
    output logic            m_done_o,
    output logic [PF_W-1:0] pf_out_o,
    output logic            miss_out_o,
    output logic            prot_out_o,
    output logic            busy_o,
    output logic [31:0]     tlb_addr_o,
    output logic            tlb_rw_o,
    input  logic [PF_W-1:0] tlb_pf_i,
    input  logic            tlb_hit_i,
    input  logic            tlb_miss_i,
    input  logic            tlb_prot_i
);

    arb_state_e      state_q, state_d;
    req_id_e         win_q, win_d;
    logic [31:0]     addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [PF_W-1:0] pf_q, pf_d;
    logic            miss_q, miss_d;
    logic            prot_q, prot_d;

    logic any_req, grant_f, arb_en, at_lim;
    logic age_inc, age_clr;

    assign any_req = f_req_i | m_req_i;
    assign grant_f = f_req_i & (~m_req_i | at_lim);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        pf_d    = pf_q;
        miss_d  = miss_q;
        prot_d  = prot_q;
        arb_en  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req && !flush_i) begin
                    arb_en  = 1'b1;
                    state_d = ST_LKUP;
                end
            end
            ST_LKUP: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    // An illegal hit+miss pair reports the miss; the frame is kept regardless.
                    pf_d    = tlb_pf_i;
                    miss_d  = tlb_miss_i | (tlb_hit_i & tlb_miss_i);
                    prot_d  = tlb_prot_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (any_req && !flush_i) begin
                    arb_en  = 1'b1;
                    state_d = ST_LKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb_en) begin
            win_d  = grant_f ? REQ_F : REQ_M;
            addr_d = grant_f ? f_vaddr_i : m_vaddr_i;
            rw_d   = grant_f ? 1'b0 : m_rw_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            win_q   <= REQ_F;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            pf_q    <= '0;
            miss_q  <= 1'b0;
            prot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            pf_q    <= pf_d;
            miss_q  <= miss_d;
            prot_q  <= prot_d;
        end
    end

    assign age_inc = arb_en & f_req_i & ~grant_f;
    assign age_clr = arb_en & (grant_f | ~f_req_i);

    tlb_arb_age_ctr #(
        .LIM(STARVE_LIM)
    ) u_age (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (age_inc),
        .clr_i   (age_clr),
        .at_lim_o(at_lim)
    );

    assign f_done_o   = (state_q == ST_RESP) && !flush_i && (win_q == REQ_F);
    assign m_done_o   = (state_q == ST_RESP) && !flush_i && (win_q == REQ_M);
    assign busy_o     = (state_q != ST_IDLE);
    assign tlb_addr_o = addr_q;
    assign tlb_rw_o   = rw_q;
    assign pf_out_o   = pf_q;
    assign miss_out_o = miss_q;
    assign prot_out_o = prot_q;

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Randomized and directed checks of tlb_port_arbiter against a transaction-level model.
module tb_tlb_port_arbiter;

    localparam int LIM = 3;
    localparam int PW  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          f_req = 1'b0, m_req = 1'b0, m_rw = 1'b0;
    logic [31:0]   f_vaddr = '0, m_vaddr = '0;
    logic          f_done, m_done, miss_out, prot_out, busy, tlb_rw;
    logic [PW-1:0] pf_out;
    logic [31:0]   tlb_addr;
    logic [PW-1:0] tlb_pf = '0;
    logic          tlb_hit = 1'b0, tlb_miss = 1'b0, tlb_prot = 1'b0;

    tlb_port_arbiter #(.STARVE_LIM(LIM), .PF_W(PW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .f_req_i(f_req), .f_vaddr_i(f_vaddr),
        .m_req_i(m_req), .m_vaddr_i(m_vaddr), .m_rw_i(m_rw),
        .f_done_o(f_done), .m_done_o(m_done),
        .pf_out_o(pf_out), .miss_out_o(miss_out), .prot_out_o(prot_out),
        .busy_o(busy), .tlb_addr_o(tlb_addr), .tlb_rw_o(tlb_rw),
        .tlb_pf_i(tlb_pf), .tlb_hit_i(tlb_hit), .tlb_miss_i(tlb_miss), .tlb_prot_i(tlb_prot)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a lookup is a transaction that is "in flight" (TLB being read)
    // then "answering" (done cycle); everything else is idle.
    bit            in_flight, answering;
    bit            t_is_m;
    logic [31:0]   t_addr;
    bit            t_rw;
    logic [PW-1:0] r_pf;
    bit            r_miss, r_prot;
    int            losses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_flight = 0; answering = 0; t_is_m = 0; t_addr = '0; t_rw = 0;
        r_pf = '0; r_miss = 0; r_prot = 0; losses = 0;
    endtask

    task automatic start_lookup();
        bit take_f;
        take_f = f_req && (!m_req || losses >= LIM);
        if (take_f) begin
            t_is_m = 0; t_addr = f_vaddr; t_rw = 0; losses = 0;
        end else begin
            t_is_m = 1; t_addr = m_vaddr; t_rw = m_rw;
            losses = f_req ? ((losses + 1 > LIM) ? LIM : losses + 1) : 0;
        end
        in_flight = 1;
    endtask

    task automatic model_step();
        if (in_flight) begin
            in_flight = 0;
            if (!flush) begin
                r_pf = tlb_pf; r_miss = tlb_miss; r_prot = tlb_prot;
                answering = 1;
            end
        end else begin
            answering = 0;
            if (!flush && (f_req || m_req)) start_lookup();
        end
    endtask

    task automatic compare_all();
        bit dn;
        dn = answering && !flush;
        chk("busy", busy, in_flight || answering);
        chk("tlb_addr", tlb_addr, t_addr);
        chk("tlb_rw", tlb_rw, t_rw);
        chk("f_done", f_done, dn && !t_is_m);
        chk("m_done", m_done, dn && t_is_m);
        chk("pf_out", pf_out, r_pf);
        chk("miss_out", miss_out, r_miss);
        chk("prot_out", prot_out, r_prot);
    endtask

    task automatic cycle(input bit f, input logic [31:0] fa, input bit m, input logic [31:0] ma,
                         input bit rw, input bit fl, input logic [PW-1:0] tpf,
                         input bit th, input bit tm, input bit tp);
        @(posedge clk);
        if (rst_n) model_step(); else model_reset();
        @(negedge clk);
        f_req = f; f_vaddr = fa; m_req = m; m_vaddr = ma; m_rw = rw; flush = fl;
        tlb_pf = tpf; tlb_hit = th; tlb_miss = tm; tlb_prot = tp;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fdone"}, f_done, 0);
        chk({tag, "_mdone"}, m_done, 0);
        chk({tag, "_addr"}, tlb_addr, 0);
        chk({tag, "_rw"}, tlb_rw, 0);
        chk({tag, "_pf"}, pf_out, 0);
        chk({tag, "_miss"}, miss_out, 0);
        chk({tag, "_prot"}, prot_out, 0);
    endtask

    initial begin
        bit got_m[$];
        bit exp_m[8];
        bit rf, rm, th;
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fetch-only hit
        cycle(1, 32'h0040_1000, 0, '0, 0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 20'h12345, 1, 0, 0);
        chk("t1_addr", tlb_addr, 32'h0040_1000);
        chk("t1_busy", busy, 1);
        cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
        chk("t1_fdone", f_done, 1);
        chk("t1_pf", pf_out, 20'h12345);
        chk("t1_miss", miss_out, 0);
        chk("t1_prot", prot_out, 0);
        idle(2);

        // MEM write with protection fault
        cycle(0, '0, 1, 32'h1000_0040, 1, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 20'h00abc, 1, 0, 1);
        chk("t2_rw", tlb_rw, 1);
        cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
        chk("t2_mdone", m_done, 1);
        chk("t2_prot", prot_out, 1);
        idle(2);

        // Both held: starvation override every fourth grant, no idle gaps
        exp_m = '{1, 1, 1, 0, 1, 1, 1, 0};
        cycle(1, 32'h0000_f000, 1, 32'h0000_e000, 0, 0, 20'h00001, 1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cycle(1, 32'h0000_f000, 1, 32'h0000_e000, 0, 0, 20'(k), 1, 0, 0);
            chk($sformatf("t3_busy%0d", k), busy, 1);
            if (f_done) got_m.push_back(0);
            if (m_done) got_m.push_back(1);
        end
        chk("t3_count", got_m.size(), 8);
        for (int i = 0; i < 8 && i < got_m.size(); i++)
            chk($sformatf("t3_grant%0d", i), got_m[i], exp_m[i]);
        idle(4);

        // MEM miss, fetch raised in the response cycle goes straight to lookup
        cycle(0, '0, 1, 32'h8000_2000, 0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 20'h11111, 0, 1, 0);
        cycle(1, 32'h0000_3000, 0, '0, 0, 0, '0, 1, 0, 0);
        chk("t4_mdone", m_done, 1);
        chk("t4_miss", miss_out, 1);
        cycle(0, '0, 0, '0, 0, 0, 20'h0abcd, 1, 0, 0);
        chk("t4_busy", busy, 1);
        chk("t4_addr", tlb_addr, 32'h0000_3000);
        cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
        chk("t4_fdone", f_done, 1);
        chk("t4_pf", pf_out, 20'h0abcd);

        // Flush during lookup, held request re-granted
        cycle(0, '0, 1, 32'h9000_0000, 1, 0, '0, 1, 0, 0);
        cycle(0, '0, 1, 32'h9000_0000, 1, 1, 20'h77777, 1, 0, 0);
        cycle(0, '0, 1, 32'h9000_0000, 1, 0, '0, 1, 0, 0);
        chk("t5_busy", busy, 0);
        chk("t5_mdone", m_done, 0);
        chk("t5_pf_held", pf_out, 20'h0abcd);
        cycle(0, '0, 0, '0, 0, 0, 20'h22222, 1, 0, 0);
        chk("t5_regrant", busy, 1);
        chk("t5_addr", tlb_addr, 32'h9000_0000);
        cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
        chk("t5_mdone2", m_done, 1);
        chk("t5_pf", pf_out, 20'h22222);
        idle(2);

        // Reset asserted mid-lookup
        cycle(1, 32'h0000_5000, 0, '0, 0, 0, '0, 1, 0, 0);
        cycle(0, '0, 0, '0, 0, 0, 20'h33333, 1, 0, 1);
        chk("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6");
        model_reset();
        cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 0, '0, 0, 0, '0, 1, 0, 0);
            chk("t6_post_busy", busy, 0);
            chk("t6_post_done", f_done | m_done, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rf = ($urandom_range(0, 2) != 0);
            rm = ($urandom_range(0, 2) != 0);
            th = $urandom_range(0, 1);
            cycle(rf, $urandom, rm, $urandom, $urandom_range(0, 1),
                  ($urandom_range(0, 15) == 0), PW'($urandom),
                  th, th ? ($urandom_range(0, 7) == 0) : 1'b1, $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
